// File: rtl/trig_dist.sv
// Trigger distributor: fans a soft (optionally external) trigger out to N_CH channels, collects acks and keeps stats.
// Optional feature: define TRIG_DIST_EXT_TRG_EN to add the synchronized EXT_TRG trigger input.
module trig_dist #(
    parameter int N_CH        = 12,
    parameter int PULSE_LEN   = 4,
    parameter int ACK_TIMEOUT = 200,
    parameter int HOLDOFF     = 16,
    parameter int CNT_W       = 32
) (
    input  logic                      CLK_80MHZ,
    input  logic                      RESET_N,
    input  logic                      TRG_SOFT,
`ifdef TRIG_DIST_EXT_TRG_EN
    input  logic                      EXT_TRG,
`endif
    input  logic [N_CH-1:0]           TRG_MASK,
    input  logic [$clog2(N_CH+1)-1:0] MIN_SCRODS_REQUIRED,
    input  logic                      CLR_STATS,
    input  logic [N_CH-1:0]           ACK,
    output logic [N_CH-1:0]           TRG,
    output logic                      BUSY,
    output logic [N_CH-1:0]           ACK_LATCHED,
    output logic [CNT_W-1:0]          TRG_COUNT,
    output logic [CNT_W-1:0]          ACCEPT_COUNT,
    output logic [CNT_W-1:0]          TIMEOUT_COUNT,
    output logic [CNT_W-1:0]          DROP_COUNT
);

    localparam int MIN_W = $clog2(N_CH + 1);
    localparam logic [31:0] PULSE_LEN_U   = 32'(PULSE_LEN);
    localparam logic [31:0] ACK_TIMEOUT_U = 32'(ACK_TIMEOUT);
    localparam logic [31:0] HOLDOFF_U     = 32'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRE     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t            state_r, state_nx_s;
    logic [15:0]       cnt_r;
    logic [N_CH-1:0]   ack_meta_r, ack_sync_r;
    logic [N_CH-1:0]   mask_r, trg_r, ack_latched_r;
    logic              soft_prev_low_r, busy_r;
    logic [CNT_W-1:0]  trg_count_r, accept_count_r, timeout_count_r, drop_count_r;
    logic              trig_req_s, start_s, accept_s, timeout_s, drop_s;
    logic              fire_last_s, wait_last_s, hold_last_s, ack_ok_s;

    function automatic logic [MIN_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [MIN_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CH; i++) begin
            c = c + MIN_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // The "previous low" flag resets to 0, so a request held high through reset never fires.
`ifdef TRIG_DIST_EXT_TRG_EN
    logic ext_meta_r, ext_sync_r, ext_prev_low_r;

    // External trigger synchronizer and edge history
    always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            ext_meta_r     <= 1'b0;
            ext_sync_r     <= 1'b0;
            ext_prev_low_r <= 1'b0;
        end else begin
            ext_meta_r     <= EXT_TRG;
            ext_sync_r     <= ext_meta_r;
            ext_prev_low_r <= ~ext_sync_r;
        end
    end

    assign trig_req_s = (TRG_SOFT & soft_prev_low_r) | (ext_sync_r & ext_prev_low_r);
`else
    assign trig_req_s = TRG_SOFT & soft_prev_low_r;
`endif

    assign fire_last_s = ({16'd0, cnt_r} + 32'd1) >= PULSE_LEN_U;
    assign wait_last_s = ({16'd0, cnt_r} + 32'd1) >= ACK_TIMEOUT_U;
    assign hold_last_s = ({16'd0, cnt_r} + 32'd1) >= HOLDOFF_U;
    assign ack_ok_s    = popcount(ack_latched_r) >= MIN_SCRODS_REQUIRED;

    // Next-state and event decode; accept is tested before timeout so it wins a tie
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        accept_s   = 1'b0;
        timeout_s  = 1'b0;
        drop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_req_s) begin
                    state_nx_s = ST_FIRE;
                    start_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FIRE: begin
                drop_s = trig_req_s;
                if (fire_last_s) begin
                    state_nx_s = ST_WAIT_ACK;
                end else begin
                    state_nx_s = ST_FIRE;
                end
            end
            ST_WAIT_ACK: begin
                drop_s = trig_req_s;
                if (ack_ok_s) begin
                    state_nx_s = ST_HOLD;
                    accept_s   = 1'b1;
                end else if (wait_last_s) begin
                    state_nx_s = ST_HOLD;
                    timeout_s  = 1'b1;
                end else begin
                    state_nx_s = ST_WAIT_ACK;
                end
            end
            ST_HOLD: begin
                drop_s = trig_req_s;
                if (hold_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, phase counter, pulse and ack collection
    always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 16'd0;
            ack_meta_r      <= '0;
            ack_sync_r      <= '0;
            mask_r          <= '0;
            trg_r           <= '0;
            ack_latched_r   <= '0;
            soft_prev_low_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_nx_s;
            cnt_r           <= (state_nx_s != state_r) ? 16'd0 : cnt_r + 16'd1;
            ack_meta_r      <= ACK;
            ack_sync_r      <= ack_meta_r;
            soft_prev_low_r <= ~TRG_SOFT;
            busy_r          <= (state_nx_s != ST_IDLE);
            if (start_s) begin
                mask_r        <= TRG_MASK;
                trg_r         <= TRG_MASK;
                ack_latched_r <= '0;
            end else begin
                trg_r <= (state_nx_s == ST_FIRE) ? trg_r : '0;
                if ((state_r == ST_FIRE) || (state_r == ST_WAIT_ACK)) begin
                    ack_latched_r <= ack_latched_r | (ack_sync_r & mask_r);
                end
            end
        end
    end

    // Saturating statistics; a clear beats any increment in the same cycle
    always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            trg_count_r     <= '0;
            accept_count_r  <= '0;
            timeout_count_r <= '0;
            drop_count_r    <= '0;
        end else if (CLR_STATS) begin
            trg_count_r     <= '0;
            accept_count_r  <= '0;
            timeout_count_r <= '0;
            drop_count_r    <= '0;
        end else begin
            trg_count_r     <= start_s   ? sat_inc(trg_count_r)     : trg_count_r;
            accept_count_r  <= accept_s  ? sat_inc(accept_count_r)  : accept_count_r;
            timeout_count_r <= timeout_s ? sat_inc(timeout_count_r) : timeout_count_r;
            drop_count_r    <= drop_s    ? sat_inc(drop_count_r)    : drop_count_r;
        end
    end

    assign TRG           = trg_r;
    assign BUSY          = busy_r;
    assign ACK_LATCHED   = ack_latched_r;
    assign TRG_COUNT     = trg_count_r;
    assign ACCEPT_COUNT  = accept_count_r;
    assign TIMEOUT_COUNT = timeout_count_r;
    assign DROP_COUNT    = drop_count_r;

endmodule

// File: tb/tb_trig_dist.sv
// Bench for trig_dist: timeline-based reference model checked every cycle plus directed scenario checks.
// Define TRIG_DIST_EXT_TRG_EN to also exercise EXT_TRG.
module tb_trig_dist;
    localparam int NC  = 12;
    localparam int PL  = 4;
    localparam int TO  = 200;
    localparam int HO  = 16;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trg_soft;
    logic [NC-1:0] trg_mask;
    logic [3:0]    min_req;
    logic          clr_stats;
    logic [NC-1:0] ack;
    logic [NC-1:0] trg, ack_latched;
    logic          busy;
    logic [CW-1:0] trg_count, accept_count, timeout_count, drop_count;
`ifdef TRIG_DIST_EXT_TRG_EN
    logic          ext_trg;
`endif

    int total = 0;
    int bad   = 0;
    logic [NC-1:0] trg_seen;

    trig_dist #(.N_CH(NC), .PULSE_LEN(PL), .ACK_TIMEOUT(TO), .HOLDOFF(HO), .CNT_W(CW)) dut (
        .CLK_80MHZ(clk),
        .RESET_N(rst_n),
        .TRG_SOFT(trg_soft),
`ifdef TRIG_DIST_EXT_TRG_EN
        .EXT_TRG(ext_trg),
`endif
        .TRG_MASK(trg_mask),
        .MIN_SCRODS_REQUIRED(min_req),
        .CLR_STATS(clr_stats),
        .ACK(ack),
        .TRG(trg),
        .BUSY(busy),
        .ACK_LATCHED(ack_latched),
        .TRG_COUNT(trg_count),
        .ACCEPT_COUNT(accept_count),
        .TIMEOUT_COUNT(timeout_count),
        .DROP_COUNT(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks each trigger as a timeline indexed from its first pulse cycle
    logic          m_busy, m_dec, m_soft_low;
    int            m_t, m_hold_start;
    logic [NC-1:0] m_mask, m_lat, m_ack_d1, m_ack_d2;
    int            m_trg_c, m_acc_c, m_to_c, m_drop_c;
    logic          m_ext_d1, m_ext_d2, m_ext_low;

    function automatic int sat(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    always @(posedge clk) begin : model
        logic          req, in_fire, in_wait, in_hold;
        logic [NC-1:0] ack_seen, e_trg;
        int            hold_len;
        logic          i_trg, i_acc, i_to, i_drop;
        if (!rst_n) begin
            m_busy = 1'b0; m_dec = 1'b0; m_soft_low = 1'b0; m_t = 0; m_hold_start = 0;
            m_mask = '0; m_lat = '0; m_ack_d1 = '0; m_ack_d2 = '0;
            m_trg_c = 0; m_acc_c = 0; m_to_c = 0; m_drop_c = 0;
            m_ext_d1 = 1'b0; m_ext_d2 = 1'b0; m_ext_low = 1'b0;
        end else begin
            i_trg = 1'b0; i_acc = 1'b0; i_to = 1'b0; i_drop = 1'b0;
            ack_seen = m_ack_d2;
            req = trg_soft && m_soft_low;
`ifdef TRIG_DIST_EXT_TRG_EN
            req = req || (m_ext_d2 && m_ext_low);
            m_ext_low = !m_ext_d2;
            m_ext_d2 = m_ext_d1;
            m_ext_d1 = ext_trg;
`endif
            m_soft_low = !trg_soft;
            m_ack_d2 = m_ack_d1;
            m_ack_d1 = ack;
            if (!m_busy) begin
                if (req) begin
                    m_busy = 1'b1; m_t = 0; m_dec = 1'b0; m_mask = trg_mask; m_lat = '0; i_trg = 1'b1;
                end
            end else begin
                i_drop = req;
                in_fire = (m_t < PL);
                in_wait = !in_fire && !m_dec;
                in_hold = m_dec;
                if (in_wait) begin
                    if ($countones(m_lat) >= int'(min_req)) begin
                        i_acc = 1'b1; m_dec = 1'b1; m_hold_start = m_t + 1;
                    end else if (m_t - PL + 1 == TO) begin
                        i_to = 1'b1; m_dec = 1'b1; m_hold_start = m_t + 1;
                    end
                end
                if (in_fire || in_wait) m_lat = m_lat | (ack_seen & m_mask);
                hold_len = (HO == 0) ? 1 : HO;
                if (in_hold && (m_t - m_hold_start + 1 >= hold_len)) m_busy = 1'b0;
                m_t = m_t + 1;
            end
            if (clr_stats) begin
                m_trg_c = 0; m_acc_c = 0; m_to_c = 0; m_drop_c = 0;
            end else begin
                if (i_trg)  m_trg_c  = sat(m_trg_c);
                if (i_acc)  m_acc_c  = sat(m_acc_c);
                if (i_to)   m_to_c   = sat(m_to_c);
                if (i_drop) m_drop_c = sat(m_drop_c);
            end
        end
        e_trg = (m_busy && m_t < PL) ? m_mask : '0;
        #1;
        chk("cyc_trg",     64'(trg),           64'(e_trg));
        chk("cyc_busy",    64'(busy),          64'(m_busy));
        chk("cyc_acklat",  64'(ack_latched),   64'(m_lat));
        chk("cyc_trgcnt",  64'(trg_count),     64'(m_trg_c));
        chk("cyc_acccnt",  64'(accept_count),  64'(m_acc_c));
        chk("cyc_tocnt",   64'(timeout_count), 64'(m_to_c));
        chk("cyc_dropcnt", 64'(drop_count),    64'(m_drop_c));
    end

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            trg_seen = trg_seen | trg;
        end
    endtask

    task automatic fire();
        trg_soft = 1'b1;
        run(1);
        trg_soft = 1'b0;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        run(1);
        clr_stats = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; trg_soft = 1'b0; trg_mask = '0; min_req = 4'd0; clr_stats = 1'b0; ack = '0;
        trg_seen = '0;
`ifdef TRIG_DIST_EXT_TRG_EN
        ext_trg = 1'b0;
`endif
        run(3);
        chk("rst_trg",  64'(trg),       64'h0);
        chk("rst_busy", 64'(busy),      64'h0);
        chk("rst_cnt",  64'(trg_count), 64'h0);
        rst_n = 1'b1;
        run(3);

        // basic accept
        trg_mask = 12'hFFF; min_req = 4'd3;
        fire();
        chk("acc_trg_c1", 64'(trg), 64'hFFF);
        run(3);
        chk("acc_trg_c4", 64'(trg), 64'hFFF);
        run(1);
        chk("acc_trg_c5", 64'(trg), 64'h0);
        run(9);
        ack = 12'h007;
        run(6);
        ack = '0;
        chk("acc_count",  64'(accept_count), 64'd1);
        chk("acc_lat",    64'(ack_latched),  64'h007);
        chk("acc_busy_h", 64'(busy),         64'd1);
        run(20);
        chk("acc_busy_l", 64'(busy),         64'd0);

        // timeout with too few enabled channels
        clear_stats();
        chk("clr_acc", 64'(accept_count), 64'd0);
        trg_mask = 12'h00F; min_req = 4'd5; ack = 12'hFFF;
        run(3);
        trg_seen = '0;
        fire();
        chk("to_trg", 64'(trg), 64'h00F);
        run(203);
        chk("to_cnt_before", 64'(timeout_count), 64'd0);
        run(1);
        chk("to_cnt_after",  64'(timeout_count), 64'd1);
        chk("to_lat",        64'(ack_latched),   64'h00F);
        run(20);
        chk("to_busy_l",  64'(busy),           64'd0);
        chk("to_hi_chan", 64'(trg_seen[11:4]), 64'h0);

        // second request during WAIT_ACK is dropped
        ack = '0; trg_mask = 12'hFFF; min_req = 4'd3;
        clear_stats();
        fire();
        run(10);
        trg_seen = '0;
        fire();
        run(5);
        chk("ovl_drop",   64'(drop_count), 64'd1);
        chk("ovl_trgcnt", 64'(trg_count),  64'd1);
        chk("ovl_nopulse", 64'(trg_seen),  64'h0);
        run(210);
        chk("ovl_busy_l", 64'(busy),          64'd0);
        chk("ovl_to",     64'(timeout_count), 64'd1);

        // reset in the second pulse cycle, with TRG_SOFT held high through release
        fire();
        run(1);
        chk("rmp_trg_pre", 64'(trg), 64'hFFF);
        rst_n = 1'b0;
        #1;
        chk("rmp_trg",  64'(trg),           64'h0);
        chk("rmp_busy", 64'(busy),          64'd0);
        chk("rmp_tc",   64'(trg_count),     64'd0);
        chk("rmp_to",   64'(timeout_count), 64'd0);
        trg_soft = 1'b1;
        run(2);
        rst_n = 1'b1;
        run(5);
        chk("rel_busy", 64'(busy),      64'd0);
        chk("rel_tc",   64'(trg_count), 64'd0);
        trg_soft = 1'b0;
        run(1);
        min_req = 4'd0;
        fire();
        run(4);
        chk("min0_acc_w1", 64'(accept_count), 64'd0);
        run(1);
        chk("min0_acc",    64'(accept_count), 64'd1);
        run(20);

        // saturation, then clear colliding with an accept
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            fire();
            run(22);
        end
        chk("sat_acc", 64'(accept_count), 64'd15);
        chk("sat_tc",  64'(trg_count),    64'd15);
        fire();
        run(4);
        clr_stats = 1'b1;
        run(1);
        clr_stats = 1'b0;
        chk("clr_acc_race", 64'(accept_count), 64'd0);
        chk("clr_tc_race",  64'(trg_count),    64'd0);
        chk("clr_busy",     64'(busy),         64'd1);
        run(20);

`ifdef TRIG_DIST_EXT_TRG_EN
        // external and soft edges reaching the trigger logic together
        clear_stats();
        ext_trg = 1'b1;
        run(2);
        fire();
        ext_trg = 1'b0;
        run(3);
        chk("ext_tc",   64'(trg_count),  64'd1);
        chk("ext_drop", 64'(drop_count), 64'd0);
        run(25);
        chk("ext_tc_end", 64'(trg_count), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
